// File: rtl/gate_sweep_if.sv
// gate_sweep_if: control, gate-stimulus and result-read signals of the gate sweep sequencer.
interface gate_sweep_if #(parameter int N_IN = 4);
   logic            start;
   logic            abort;
   logic [N_IN-1:0] stim;
   logic            e_in;
   logic            f_in;
   logic            g_in;
   logic            busy;
   logic            done;
   logic [N_IN-1:0] vec_idx;
   logic [N_IN-1:0] rd_addr;
   logic [2:0]      rd_data;
   logic [N_IN:0]   err_cnt;
   modport master (output start, abort, e_in, f_in, g_in, rd_addr,
                   input  stim, busy, done, vec_idx, rd_data, err_cnt);
   modport slave  (input  start, abort, e_in, f_in, g_in, rd_addr,
                   output stim, busy, done, vec_idx, rd_data, err_cnt);
endinterface

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: clocked exhaustive sweep of gate inputs with settle, capture into result RAM and registered read.
// NOR_CHECK_EN adds a NOR check on e with a saturating mismatch counter; otherwise err_cnt is 0.
module gate_sweep_ctrl #(
   parameter int N_IN       = 4,
   parameter int SETTLE_CYC = 4,
   parameter int START_VEC  = 0
) (
   input logic        clk,
   input logic        rst,
   gate_sweep_if.slave bus
);
   localparam int NV = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
   localparam logic [N_IN-1:0] FIRST_VEC = N_IN'(START_VEC);
   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, FINISH} state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q;
   logic [N_IN-1:0] stim_q, vec_q;
   logic            busy_q, done_q;
   logic [2:0]      rd_q;
   logic [2:0]      ram [NV];
   logic            go, adv;

   assign go  = state_q == IDLE && bus.start && !bus.abort;
   assign adv = state_q == CAPTURE && vec_q != LAST_VEC && !bus.abort;

   always_comb begin
      state_d = bus.abort                                ? IDLE :
                go                                       ? SETTLE :
                (state_q == SETTLE && cnt_q == CNT_LAST) ? CAPTURE :
                state_q == CAPTURE                       ? (vec_q == LAST_VEC ? FINISH : SETTLE) :
                state_q == FINISH                        ? IDLE : state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         stim_q  <= '0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= state_d == SETTLE || state_d == CAPTURE;
         done_q  <= state_q == FINISH && !bus.abort;
         cnt_q   <= state_q == SETTLE ? cnt_q + 8'd1 : 8'd0;
         rd_q    <= ram[bus.rd_addr];
         if (go) begin
            vec_q  <= FIRST_VEC;
            stim_q <= FIRST_VEC;
         end else if (adv) begin
            vec_q  <= vec_q + 1'b1;
            stim_q <= vec_q + 1'b1;
         end
      end
   end

   // Result RAM is deliberately not reset; an aborted capture still lands.
   always_ff @(posedge clk) begin
      if (state_q == CAPTURE) ram[vec_q] <= {bus.g_in, bus.f_in, bus.e_in};
   end

`ifdef NOR_CHECK_EN
   logic [N_IN:0] err_q;
   always_ff @(posedge clk) begin
      if (rst || go) err_q <= '0;
      else if (state_q == CAPTURE && bus.e_in != ~|stim_q && err_q != '1) err_q <= err_q + 1'b1;
   end
   assign bus.err_cnt = err_q;
`else
   assign bus.err_cnt = '0;
`endif

   assign bus.stim    = stim_q;
   assign bus.vec_idx = vec_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: gate model drives e/f/g, read results checked through a scoreboard queue and a vector table.
module tb_gate_sweep_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef NOR_CHECK_EN
   localparam bit NC = 1'b1;
`else
   localparam bit NC = 1'b0;
`endif

   gate_sweep_if #(.N_IN(4)) m0 ();
   gate_sweep_if #(.N_IN(4)) m1 ();

   gate_sweep_ctrl #(.N_IN(4)) dut (.clk(clk), .rst(rst), .bus(m0));
   gate_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(m1));

   int   e_mode = 0;
   logic g_inv  = 1'b0;

   function automatic logic [2:0] model(input logic [3:0] v, input logic inv);
      return {(^v) ^ inv, (v[0] & v[1]) | (v[2] & v[3]), ~|v};
   endfunction

   assign m0.e_in = e_mode == 1 ? 1'b0 : e_mode == 2 ? 1'b1 : ~|m0.stim;
   assign m0.f_in = (m0.stim[0] & m0.stim[1]) | (m0.stim[2] & m0.stim[3]);
   assign m0.g_in = (^m0.stim) ^ g_inv;
   assign m1.e_in = ~|m1.stim;
   assign m1.f_in = (m1.stim[0] & m1.stim[1]) | (m1.stim[2] & m1.stim[3]);
   assign m1.g_in = ^m1.stim;

   typedef struct {
      logic [3:0] addr;
      logic [2:0] exp;
   } rd_vec_t;

   rd_vec_t    tbl[16];
   logic [2:0] sbq[$];
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start0();
      m0.start = 1'b1;
      tick();
      m0.start = 1'b0;
   endtask

   task automatic wait_vec(input logic [3:0] v);
      int k = 0;
      while (m0.vec_idx !== v && k < 200) begin
         tick();
         k++;
      end
      check($sformatf("reach vec %0d", v), m0.vec_idx, v);
   endtask

   task automatic wait_done();
      int k = 0;
      while (m0.done !== 1'b1 && k < 300) begin
         tick();
         k++;
      end
      check("done seen", m0.done, 1);
   endtask

   task automatic sweep0(output int cyc, output int bsy);
      start0();
      cyc = 0;
      bsy = int'(m0.busy);
      while (m0.done !== 1'b1 && cyc < 300) begin
         tick();
         cyc++;
         if (m0.busy === 1'b1) bsy++;
      end
   endtask

   task automatic no_done(input string name, input int n);
      int d = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (m0.done !== 1'b0) d++;
      end
      check(name, d, 0);
   endtask

   task automatic read0(input string name, input logic [3:0] a, input logic [2:0] exp);
      m0.rd_addr = a;
      sbq.push_back(exp);
      tick();
      check(name, m0.rd_data, sbq.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, bsy, bad;
      m0.start = 0; m0.abort = 0; m0.rd_addr = '0;
      m1.start = 0; m1.abort = 0; m1.rd_addr = '0;
      repeat (3) tick();
      check("rst stim", m0.stim, 0);
      check("rst vec_idx", m0.vec_idx, 0);
      check("rst busy", m0.busy, 0);
      check("rst done", m0.done, 0);
      check("rst rd_data", m0.rd_data, 0);
      check("rst err_cnt", m0.err_cnt, 0);
      rst = 1'b0;
      tick();

      // reset mid-sweep
      start0();
      repeat (29) tick();
      check("pre-rst stim", m0.stim, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst stim", m0.stim, 0);
      check("midrst vec_idx", m0.vec_idx, 0);
      check("midrst busy", m0.busy, 0);
      no_done("midrst no done", 100);

      // full sweep, default timing
      sweep0(cyc, bsy);
      check("done latency", cyc, 81);
      check("busy cycles", bsy, 80);
      check("err after sweep", m0.err_cnt, 0);
      tick();
      check("done one cycle", m0.done, 0);
      check("stim holds last", m0.stim, 15);
      for (int i = 0; i < 16; i++) tbl[i] = '{addr: 4'(i), exp: model(4'(i), 1'b0)};
      for (int i = 0; i < 16; i++) read0($sformatf("ram[%0d]", tbl[i].addr), tbl[i].addr, tbl[i].exp);

      // SETTLE_CYC=1 instance
      m1.start = 1'b1;
      tick();
      m1.start = 1'b0;
      cyc = 0;
      bsy = int'(m1.busy);
      bad = (m1.stim !== 4'd0) ? 1 : 0;
      while (m1.done !== 1'b1 && cyc < 300) begin
         tick();
         cyc++;
         if (m1.busy === 1'b1) bsy++;
         if (cyc < 32 && m1.stim !== 4'(cyc / 2)) bad++;
      end
      check("s1 done latency", cyc, 33);
      check("s1 busy cycles", bsy, 32);
      check("s1 stim cadence", bad, 0);

      // ignored start, then abort during capture of vector 9
      g_inv = 1'b1;
      start0();
      wait_vec(5);
      m0.start = 1'b1;
      tick();
      m0.start = 1'b0;
      check("no restart", m0.vec_idx, 5);
      wait_vec(6);
      wait_vec(9);
      repeat (4) tick();
      m0.abort = 1'b1;
      tick();
      m0.abort = 1'b0;
      check("abort busy", m0.busy, 0);
      check("abort vec hold", m0.vec_idx, 9);
      no_done("abort no done", 100);
      for (int i = 0; i <= 10; i++) read0($sformatf("abort ram[%0d]", i), 4'(i), model(4'(i), i <= 9));

      // read colliding with capture of the same address
      g_inv = 1'b0;
      start0();
      wait_vec(3);
      repeat (4) tick();
      read0("rdw old", 4'd3, model(4'd3, 1'b1));
      read0("rdw new", 4'd3, model(4'd3, 1'b0));
      wait_done();

      // e stuck faults
      e_mode = 1;
      sweep0(cyc, bsy);
      check("stuck0 err_cnt", m0.err_cnt, NC ? 1 : 0);
      repeat (3) tick();
      check("stuck0 err hold", m0.err_cnt, NC ? 1 : 0);
      read0("stuck0 ram[0]", 4'd0, model(4'd0, 1'b0) & 3'b110);
      e_mode = 2;
      sweep0(cyc, bsy);
      check("stuck1 err_cnt", m0.err_cnt, NC ? 15 : 0);
      e_mode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Sequencer for the 4-input gate lab datapath (inputs a,b,c,d; outputs e,f,g). On a start pulse it steps the gate inputs through every input combination. It waits a programmable settle time per vector, captures e/f/g into an internal result RAM, and exposes the results through a registered read port. It sits between the lab top-level/control logic and the combinational gate unit, replacing free-running toggle stimulus with a deterministic, clocked sweep.

Parameters:
N_IN, 4, number of gate inputs; sweep covers 2^N_IN vectors (supported 1..6)
SETTLE_CYC, 4, clock cycles stimulus is held before capture (min 1, max 255)
START_VEC, 0, first vector value after start (must be < 2^N_IN)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a sweep when IDLE, ignored otherwise
abort  input  1  level; forces return to IDLE next cycle, results kept
stim  output  N_IN  drives gate inputs; stim[0]=a, stim[1]=b, stim[2]=c, stim[3]=d
e_in  input  1  gate output e
f_in  input  1  gate output f
g_in  input  1  gate output g
busy  output  1  high in SETTLE/CAPTURE states
done  output  1  one-cycle pulse after last vector captured
vec_idx  output  N_IN  vector currently applied
rd_addr  input  N_IN  result RAM read address
rd_data  output  3  {g,f,e} captured for rd_addr, 1-cycle read latency
err_cnt  output  N_IN+1  mismatch count (NOR_CHECK_EN only; else tied 0)

Behaviour:
- Clock clk; reset rst is synchronous, active-high. All registers update on the rising edge of clk.
- Reset: state=IDLE, stim=0, vec_idx=0, busy=0, done=0, rd_data=0, err_cnt=0, settle counter=0. RAM contents are undefined after reset and are not cleared.
- States: IDLE, SETTLE, CAPTURE, FINISH.
- IDLE: when start=1, load vec_idx=START_VEC and stim=START_VEC, clear the settle counter and err_cnt, then go to SETTLE.
- SETTLE: increment the settle counter each cycle. When counter==SETTLE_CYC-1, go to CAPTURE. stim is stable throughout.
- CAPTURE, single cycle:
  - write {g_in,f_in,e_in} to RAM[vec_idx];
  - if vec_idx==2^N_IN-1, go to FINISH;
  - else vec_idx<=vec_idx+1, stim<=vec_idx+1, counter<=0, go to SETTLE.
- FINISH: done=1 for exactly one cycle, then go to IDLE. stim holds the last vector.
- Wrap-around: the sweep ends at 2^N_IN-1 and never wraps to 0. With START_VEC>0, vectors below START_VEC are not captured.
- Timing: per-vector time is SETTLE_CYC+1 cycles. Total time from start to done is (2^N_IN-START_VEC)*(SETTLE_CYC+1)+1 cycles. With defaults, done asserts 81 cycles after the start edge.
- start while busy or in FINISH: ignored, no restart.
- abort has priority over all transitions except rst. On abort=1 the next state is IDLE, busy=0, and done is not pulsed. A CAPTURE coincident with abort still writes its RAM entry.
- rst mid-sweep: returns immediately to reset values; the sweep is lost.
- Read port: rd_data <= RAM[rd_addr] every cycle, independent of state.
  - Read and write to the same address in the same cycle returns the old data.
  - The new value is visible on the next read.
- Capture samples e_in/f_in/g_in combinationally at the CAPTURE edge. Inputs are assumed settled, which is guaranteed by SETTLE_CYC.

Optional Feature:
Macro NOR_CHECK_EN.
- Defined:
  - at each CAPTURE, compare e_in against the expected value ~|stim;
  - increment err_cnt (saturating at 2^(N_IN+1)-1) on mismatch;
  - err_cnt is cleared on start and on rst, and held after done.
- Undefined: no comparator logic; err_cnt is driven constant 0.

Test Plan:
1. Reset mid-sweep: start, then rst at cycle 30 -> next cycle stim=0, vec_idx=0, busy=0, no done pulse. A new start runs a full sweep.
2. Full sweep with defaults and an ideal NOR model on e -> done exactly 81 cycles after start. RAM[0].e=1 and RAM[1..15].e=0. With NOR_CHECK_EN, err_cnt=0.
3. Settle timing with SETTLE_CYC=1 -> stim advances every 2 cycles, done 33 cycles after start, busy high for 32 cycles.
4. Ignored start and abort:
   - start pulsed again at vec 5 -> no restart; vec_idx continues to 6.
   - abort at vec 9 -> IDLE next cycle, no done, RAM[0..9] valid.
5. Fault injection (NOR_CHECK_EN): force e_in stuck at 0 -> err_cnt=1 after done. Force e_in stuck at 1 -> err_cnt=15.
6. Read port: after a sweep, rd_addr=3 -> rd_data equals {g,f,e} of vector 3 one cycle later. Read during CAPTURE of the same address returns the old data.
